// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 opcodes, instruction format enum and
// format-property helpers used by the slot decoder and hazard logic.
package decode_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Formats whose instructions write rd.
  function automatic logic fmt_writes_rd(input logic [2:0] f);
    return (f == FMT_R) || (f == FMT_I) || (f == FMT_U) || (f == FMT_J);
  endfunction

  // Formats whose instructions read rs2.
  function automatic logic fmt_reads_rs2(input logic [2:0] f);
    return (f == FMT_R) || (f == FMT_S) || (f == FMT_B);
  endfunction

endpackage

// File: rtl/decode_slot.sv
// Combinational single-instruction decoder: field split, format
// classification, sign-extended immediate and illegal flag.
// Ports: instr in; opcode/rd/func3/rs1/rs2/func7/imm/fmt/illegal out.
module decode_slot
  import decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [6:0]         opcode,
  output logic [4:0]         rd,
  output logic [2:0]         func3,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [6:0]         func7,
  output logic [INSTR_W-1:0] imm,
  output logic [2:0]         fmt,
  output logic               illegal
);

  fmt_e fmt_d;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign func3  = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign func7  = instr[31:25];
  assign fmt    = fmt_d;

  // Opcode to format map; every supported opcode ends in 2'b11.
  always_comb begin
    fmt_d = FMT_ILL;
    case (instr[6:0])
      OP_R:                             fmt_d = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS: fmt_d = FMT_I;
      OP_STORE:                         fmt_d = FMT_S;
      OP_BRANCH:                        fmt_d = FMT_B;
      OP_LUI, OP_AUIPC:                 fmt_d = FMT_U;
      OP_JAL:                           fmt_d = FMT_J;
      default:                          fmt_d = FMT_ILL;
    endcase
  end

  assign illegal = (fmt_d == FMT_ILL) || (instr[1:0] != 2'b11);

  // Immediate assembly by format; R and ILL yield zero.
  always_comb begin
    imm = '0;
    case (fmt_d)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_n.sv
// Registered ISSUE_W-wide decode stage with valid/ready handshakes and flush.
// Ports: clk, rst_n, flush; in_valid/in_ready with instr_i, pc_i, slot_vld_i;
// out_valid/out_ready with registered slot_vld_o, pc_o, decoded fields,
// imm_o, fmt_o, illegal_o, raw_o.
// Optional macro DEC_HAZARD_EN: enables the intra-bundle RAW comparator;
// otherwise raw_o is tied to 0.
module decode_stage_n
  import decode_pkg::*;
#(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned PC_W    = 8,
  parameter int unsigned XLEN    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ISSUE_W*INSTR_W-1:0] instr_i,
  input  logic [ISSUE_W*PC_W-1:0]    pc_i,
  input  logic [ISSUE_W-1:0]         slot_vld_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ISSUE_W-1:0]         slot_vld_o,
  output logic [ISSUE_W*PC_W-1:0]    pc_o,
  output logic [ISSUE_W*7-1:0]       opcode_o,
  output logic [ISSUE_W*5-1:0]       rd_o,
  output logic [ISSUE_W*3-1:0]       func3_o,
  output logic [ISSUE_W*5-1:0]       rs1_o,
  output logic [ISSUE_W*5-1:0]       rs2_o,
  output logic [ISSUE_W*7-1:0]       func7_o,
  output logic [ISSUE_W*XLEN-1:0]    imm_o,
  output logic [ISSUE_W*3-1:0]       fmt_o,
  output logic [ISSUE_W-1:0]         illegal_o,
  output logic [ISSUE_W-1:0]         raw_o
);

  logic [ISSUE_W*7-1:0]    opcode_c;
  logic [ISSUE_W*5-1:0]    rd_c;
  logic [ISSUE_W*3-1:0]    func3_c;
  logic [ISSUE_W*5-1:0]    rs1_c;
  logic [ISSUE_W*5-1:0]    rs2_c;
  logic [ISSUE_W*7-1:0]    func7_c;
  logic [ISSUE_W*XLEN-1:0] imm_c;
  logic [ISSUE_W*3-1:0]    fmt_c;
  logic [ISSUE_W-1:0]      illegal_c;
  logic [ISSUE_W-1:0]      raw_c;
  logic                    load;

  // One decoder per slot.
  for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
    decode_slot u_dec (
      .instr   (instr_i[k*INSTR_W +: INSTR_W]),
      .opcode  (opcode_c[k*7 +: 7]),
      .rd      (rd_c[k*5 +: 5]),
      .func3   (func3_c[k*3 +: 3]),
      .rs1     (rs1_c[k*5 +: 5]),
      .rs2     (rs2_c[k*5 +: 5]),
      .func7   (func7_c[k*7 +: 7]),
      .imm     (imm_c[k*XLEN +: XLEN]),
      .fmt     (fmt_c[k*3 +: 3]),
      .illegal (illegal_c[k])
    );
  end

`ifdef DEC_HAZARD_EN
  // Slot k is flagged when any older valid slot writes a register it reads.
  always_comb begin
    raw_c = '0;
    for (int unsigned k = 1; k < ISSUE_W; k++) begin
      for (int unsigned j = 0; j < k; j++) begin
        if (slot_vld_i[j] && slot_vld_i[k] &&
            fmt_writes_rd(fmt_c[j*3 +: 3]) && (rd_c[j*5 +: 5] != 5'd0) &&
            ((rd_c[j*5 +: 5] == rs1_c[k*5 +: 5]) ||
             ((rd_c[j*5 +: 5] == rs2_c[k*5 +: 5]) && fmt_reads_rs2(fmt_c[k*3 +: 3])))) begin
          raw_c[k] = 1'b1;
        end
      end
    end
  end
`else
  assign raw_c = '0;
`endif

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign load     = in_valid && in_ready;

  // One-entry pipeline register; flush dominates, then load, then consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      slot_vld_o <= '0;
      pc_o       <= '0;
      opcode_o   <= '0;
      rd_o       <= '0;
      func3_o    <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      func7_o    <= '0;
      imm_o      <= '0;
      fmt_o      <= '0;
      illegal_o  <= '0;
      raw_o      <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      slot_vld_o <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      slot_vld_o <= slot_vld_i;
      pc_o       <= pc_i;
      opcode_o   <= opcode_c;
      rd_o       <= rd_c;
      func3_o    <= func3_c;
      rs1_o      <= rs1_c;
      rs2_o      <= rs2_c;
      func7_o    <= func7_c;
      imm_o      <= imm_c;
      fmt_o      <= fmt_c;
      illegal_o  <= illegal_c & slot_vld_i;
      raw_o      <= raw_c & slot_vld_i;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_n.sv
module tb_decode_stage_n;

  localparam int W  = 2;
  localparam int PW = 8;
`ifdef DEC_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  localparam logic [31:0] ADDI = 32'h00A00093;  // addi x1,x0,10
  localparam logic [31:0] ADD  = 32'h00208133;  // add x2,x1,x2
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] LUI  = 32'h123450B7;
  localparam logic [31:0] SW   = 32'h00112623;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W*32-1:0] instr_i = '0;
  logic [W*PW-1:0] pc_i = '0;
  logic [W-1:0]    slot_vld_i = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    slot_vld_o;
  logic [W*PW-1:0] pc_o;
  logic [W*7-1:0]  opcode_o;
  logic [W*5-1:0]  rd_o;
  logic [W*3-1:0]  func3_o;
  logic [W*5-1:0]  rs1_o;
  logic [W*5-1:0]  rs2_o;
  logic [W*7-1:0]  func7_o;
  logic [W*32-1:0] imm_o;
  logic [W*3-1:0]  fmt_o;
  logic [W-1:0]    illegal_o;
  logic [W-1:0]    raw_o;

  int checks = 0;
  int failures = 0;

  decode_stage_n #(.ISSUE_W(W), .PC_W(PW), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr_i(instr_i), .pc_i(pc_i), .slot_vld_i(slot_vld_i), .out_valid(out_valid),
    .out_ready(out_ready), .slot_vld_o(slot_vld_o), .pc_o(pc_o), .opcode_o(opcode_o),
    .rd_o(rd_o), .func3_o(func3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .func7_o(func7_o),
    .imm_o(imm_o), .fmt_o(fmt_o), .illegal_o(illegal_o), .raw_o(raw_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference format classification from the opcode table.
  function automatic logic [2:0] m_fmt(input logic [31:0] i);
    if (i[1:0] != 2'b11) return 3'd7;
    case (i[6:0])
      7'h33:                      return 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      default:                    return 3'd7;
    endcase
  endfunction

  // Reference immediate via signed arithmetic on the instruction word.
  function automatic logic [31:0] m_imm(input logic [31:0] i);
    int s;
    int v;
    s = $signed(i) >>> 31;
    v = 0;
    case (m_fmt(i))
      3'd1: v = $signed(i) >>> 20;
      3'd2: v = s * 4096 + int'(i[31:25]) * 32 + int'(i[11:7]);
      3'd3: v = s * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      3'd4: v = int'(i & 32'hFFFFF000);
      3'd5: v = s * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [1:0] m_raw(input logic [31:0] i0, input logic [31:0] i1,
                                       input logic [1:0] m);
    logic [4:0] rdj;
    logic [2:0] f0;
    logic [2:0] f1;
    logic [1:0] r;
    rdj = i0[11:7];
    f0  = m_fmt(i0);
    f1  = m_fmt(i1);
    r   = 2'b00;
    if (m == 2'b11 && (f0 == 3'd0 || f0 == 3'd1 || f0 == 3'd4 || f0 == 3'd5) && rdj != 5'd0 &&
        (rdj == i1[19:15] || (rdj == i1[24:20] && (f1 == 3'd0 || f1 == 3'd2 || f1 == 3'd3))))
      r[1] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] op;
    if ($urandom_range(0, 4) == 0) return $urandom;
    case ($urandom_range(0, 10))
      0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h67;
      4: op = 7'h73; 5: op = 7'h23; 6: op = 7'h63; 7: op = 7'h37;
      8: op = 7'h17; 9: op = 7'h6F; default: op = 7'h00;
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] i1, input logic [31:0] i0,
                       input logic [7:0] p1, input logic [7:0] p0, input logic [1:0] m,
                       input logic ordy, input logic fl);
    in_valid   = iv;
    instr_i    = {i1, i0};
    pc_i       = {p1, p0};
    slot_vld_i = m;
    out_ready  = ordy;
    flush      = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;

  vec_t vt[10];

  // Random-phase model state
  logic        mv;
  logic [1:0]  mmask;
  logic [31:0] mi[2];
  logic [7:0]  mp[2];
  logic [1:0]  mraw;

  initial begin
    vt[0] = '{32'h00A00093, 3'd1, 32'd10,        1'b0, 5'd1};
    vt[1] = '{32'h00208133, 3'd0, 32'd0,         1'b0, 5'd2};
    vt[2] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC,  1'b0, 5'd29};
    vt[3] = '{32'hFFDFF06F, 3'd5, 32'hFFFFFFFC,  1'b0, 5'd0};
    vt[4] = '{32'h00000000, 3'd7, 32'd0,         1'b1, 5'd0};
    vt[5] = '{32'h123450B7, 3'd4, 32'h12345000,  1'b0, 5'd1};
    vt[6] = '{32'h00112623, 3'd2, 32'd12,        1'b0, 5'd12};
    vt[7] = '{32'h00A00090, 3'd7, 32'd0,         1'b1, 5'd1};
    vt[8] = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF,  1'b0, 5'd1};
    vt[9] = '{32'hFFFFF017, 3'd4, 32'hFFFFF000,  1'b0, 5'd0};

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_slot_vld", 32'(slot_vld_o), 32'd0);
    chk("rst_imm", imm_o[31:0], 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    cyc();

    // Single load: addi in slot0, add in slot1
    drive(1'b1, ADD, ADDI, 8'h08, 8'h04, 2'b11, 1'b1, 1'b0);
    cyc();
    chk("ld_out_valid", 32'(out_valid), 32'd1);
    chk("ld_slot_vld", 32'(slot_vld_o), 32'd3);
    chk("ld_pc", 32'(pc_o), 32'h0804);
    chk("ld_fmt0", 32'(fmt_o[2:0]), 32'd1);
    chk("ld_rd0", 32'(rd_o[4:0]), 32'd1);
    chk("ld_imm0", imm_o[31:0], 32'd10);
    chk("ld_fmt1", 32'(fmt_o[5:3]), 32'd0);
    chk("ld_rd1", 32'(rd_o[9:5]), 32'd2);
    chk("ld_rs1_1", 32'(rs1_o[9:5]), 32'd1);
    chk("ld_rs2_1", 32'(rs2_o[9:5]), 32'd2);
    chk("ld_imm1", imm_o[63:32], 32'd0);
    chk("ld_raw", 32'(raw_o), HZ ? 32'd2 : 32'd0);

    // Table of single-instruction vectors in slot0
    for (int n = 0; n < 10; n++) begin
      drive(1'b1, NOP, vt[n].instr, 8'h08, 8'h04, 2'b11, 1'b1, 1'b0);
      cyc();
      chk($sformatf("vec%0d_valid", n), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_fmt", n), 32'(fmt_o[2:0]), 32'(vt[n].fmt));
      chk($sformatf("vec%0d_imm", n), imm_o[31:0], vt[n].imm);
      chk($sformatf("vec%0d_ill", n), 32'(illegal_o[0]), 32'(vt[n].ill));
      chk($sformatf("vec%0d_rd", n), 32'(rd_o[4:0]), 32'(vt[n].rd));
    end

    // Illegal and masked slot 1
    drive(1'b1, 32'h0, ADDI, 8'h08, 8'h04, 2'b11, 1'b1, 1'b0);
    cyc();
    chk("ill_flag1", 32'(illegal_o), 32'd2);
    chk("ill_fmt1", 32'(fmt_o[5:3]), 32'd7);
    drive(1'b1, 32'h0, ADDI, 8'h08, 8'h04, 2'b01, 1'b1, 1'b0);
    cyc();
    chk("mask_ill1", 32'(illegal_o), 32'd0);
    chk("mask_slot_vld", 32'(slot_vld_o), 32'd1);
    chk("mask_fmt1", 32'(fmt_o[5:3]), 32'd7);
    drive(1'b1, ADD, ADDI, 8'h08, 8'h04, 2'b00, 1'b1, 1'b0);
    cyc();
    chk("zmask_valid", 32'(out_valid), 32'd1);
    chk("zmask_slot_vld", 32'(slot_vld_o), 32'd0);
    chk("zmask_raw", 32'(raw_o), 32'd0);

    // Hazard cases
    drive(1'b1, ADD, 32'h00A00013, 8'h08, 8'h04, 2'b11, 1'b1, 1'b0);
    cyc();
    chk("hz_rd0_raw", 32'(raw_o), 32'd0);
    drive(1'b1, ADD, ADDI, 8'h08, 8'h04, 2'b10, 1'b1, 1'b0);
    cyc();
    chk("hz_masked_raw", 32'(raw_o), 32'd0);

    // Backpressure: stall three cycles then consume+load with no bubble
    drive(1'b1, ADD, ADDI, 8'h08, 8'h04, 2'b11, 1'b1, 1'b0);
    cyc();
    drive(1'b1, SW, LUI, 8'h14, 8'h10, 2'b11, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      cyc();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_pc_hold", 32'(pc_o), 32'h0804);
      chk("bp_imm_hold", imm_o[31:0], 32'd10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_pc", 32'(pc_o), 32'h1410);
    chk("bp_next_imm", imm_o[31:0], 32'h12345000);
    chk("bp_next_fmt1", 32'(fmt_o[5:3]), 32'd2);
    drive(1'b0, SW, LUI, 8'h14, 8'h10, 2'b11, 1'b1, 1'b0);
    cyc();
    chk("consume_valid", 32'(out_valid), 32'd0);

    // Flush mid-stall
    drive(1'b1, ADD, ADDI, 8'h08, 8'h04, 2'b11, 1'b1, 1'b0);
    cyc();
    drive(1'b1, SW, LUI, 8'h14, 8'h10, 2'b11, 1'b0, 1'b1);
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_slot_vld", 32'(slot_vld_o), 32'd0);
    drive(1'b0, SW, LUI, 8'h14, 8'h10, 2'b11, 1'b0, 1'b0);
    cyc();
    chk("fl_not_captured", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stall
    drive(1'b1, ADD, ADDI, 8'h08, 8'h04, 2'b11, 1'b1, 1'b0);
    cyc();
    drive(1'b1, SW, LUI, 8'h14, 8'h10, 2'b11, 1'b0, 1'b0);
    cyc();
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_slot_vld", 32'(slot_vld_o), 32'd0);
    chk("ar_pc", 32'(pc_o), 32'd0);
    #2 rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 8'h0, 8'h0, 2'b00, 1'b0, 1'b1);
    cyc();

    // Randomized traffic against the reference model
    mv = 1'b0;
    mmask = 2'b00;
    mraw = 2'b00;
    mi[0] = '0; mi[1] = '0; mp[0] = '0; mp[1] = '0;
    for (int c = 0; c < 400; c++) begin
      logic        iv, ordy, fl, rdy;
      logic [31:0] i0, i1;
      logic [7:0]  p0, p1;
      logic [1:0]  m;
      chk("rnd_valid", 32'(out_valid), 32'(mv));
      chk("rnd_slot_vld", 32'(slot_vld_o), 32'(mmask));
      if (mv) begin
        for (int k = 0; k < 2; k++) begin
          chk("rnd_pc", 32'(pc_o[k*8 +: 8]), 32'(mp[k]));
          chk("rnd_opcode", 32'(opcode_o[k*7 +: 7]), 32'(mi[k][6:0]));
          chk("rnd_rd", 32'(rd_o[k*5 +: 5]), 32'(mi[k][11:7]));
          chk("rnd_func3", 32'(func3_o[k*3 +: 3]), 32'(mi[k][14:12]));
          chk("rnd_rs1", 32'(rs1_o[k*5 +: 5]), 32'(mi[k][19:15]));
          chk("rnd_rs2", 32'(rs2_o[k*5 +: 5]), 32'(mi[k][24:20]));
          chk("rnd_func7", 32'(func7_o[k*7 +: 7]), 32'(mi[k][31:25]));
          chk("rnd_imm", imm_o[k*32 +: 32], m_imm(mi[k]));
          chk("rnd_fmt", 32'(fmt_o[k*3 +: 3]), 32'(m_fmt(mi[k])));
          chk("rnd_ill", 32'(illegal_o[k]), 32'((m_fmt(mi[k]) == 3'd7) && mmask[k]));
          chk("rnd_raw", 32'(raw_o[k]), 32'(mraw[k]));
        end
      end
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 15) == 0);
      i0   = rnd_instr();
      i1   = rnd_instr();
      p0   = 8'($urandom);
      p1   = 8'($urandom);
      m    = 2'($urandom);
      drive(iv, i1, i0, p1, p0, m, ordy, fl);
      rdy = (!mv || ordy) && !fl;
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'(rdy));
      if (fl) begin
        mv = 1'b0;
        mmask = 2'b00;
      end else if (iv && rdy) begin
        mv = 1'b1;
        mmask = m;
        mi[0] = i0; mi[1] = i1;
        mp[0] = p0; mp[1] = p1;
        mraw = HZ ? m_raw(i0, i1, m) : 2'b00;
      end else if (ordy) begin
        mv = 1'b0;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
